// File: rtl/data_break_ctrl.sv
// Single-channel data-break front end: CA/WC registers, break handshake with state_machine, block completion.
// Optional interrupt output int_req_db is built when DB_OVERFLOW_INT_EN is defined.
module data_break_ctrl #(
  parameter int         FIELD_W   = 3,
  parameter int         TIMEOUT   = 255,
  parameter logic [4:0] DB0_STATE = 5'd8,
  parameter logic [4:0] DB1_STATE = 5'd9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         state,
  input  logic               ld_ca,
  input  logic               ld_wc,
  input  logic [11:0]        ld_data,
  input  logic [FIELD_W-1:0] ld_field,
  input  logic               dir_to_disk,
  input  logic               dev_req,
  input  logic [11:0]        dev_wdata,
  input  logic [11:0]        mem_rdata,
  output logic               data_break,
  output logic               to_disk,
  output logic [11:0]        db_addr,
  output logic [FIELD_W-1:0] db_field,
  output logic [11:0]        db_wdata,
  output logic               dev_ack,
  output logic [11:0]        dev_rdata,
  output logic               busy,
  output logic               done,
`ifdef DB_OVERFLOW_INT_EN
  output logic               int_req_db,
`endif
  output logic               db_timeout
);

  typedef enum logic [2:0] {IDLE, REQ, XFER0, XFER1, DONE_CHK} fsm_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fsm_t               fsm, fsm_nxt;
  logic [CNT_W-1:0]   to_cnt;
  logic [11:0]        ca, wc;
  logic [FIELD_W-1:0] field;
  logic               dir;
  logic               accept, timeout_hit;

  assign accept      = (fsm == IDLE) && dev_req && busy;
  assign timeout_hit = (fsm == REQ) && (state != DB0_STATE) &&
                       (to_cnt == CNT_W'(TIMEOUT - 1));
  assign db_addr     = ca;
  assign db_field    = field;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:     if (accept) fsm_nxt = REQ;
      REQ:      if (state == DB0_STATE) fsm_nxt = XFER0;
                else if (timeout_hit)   fsm_nxt = IDLE;
      XFER0:    if (state == DB1_STATE) fsm_nxt = XFER1;
      XFER1:    fsm_nxt = DONE_CHK;
      DONE_CHK: fsm_nxt = IDLE;
      default:  fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_break = (fsm == REQ) || (fsm == XFER0);
    to_disk    = dir && ((fsm == REQ) || (fsm == XFER0) || (fsm == XFER1));
    dev_ack    = (fsm == XFER1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ca         <= '0;
      wc         <= '0;
      field      <= '0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      db_timeout <= 1'b0;
      db_wdata   <= '0;
      dev_rdata  <= '0;
      to_cnt     <= '0;
`ifdef DB_OVERFLOW_INT_EN
      int_req_db <= 1'b0;
`endif
    end else begin
      if (fsm == IDLE) begin
        if (ld_ca) begin
          ca    <= ld_data;
          field <= ld_field;
        end
        if (ld_wc) begin
          wc         <= ld_data;
          busy       <= (ld_data != 12'd0);
          done       <= 1'b0;
          db_timeout <= 1'b0;
          dir        <= dir_to_disk;
`ifdef DB_OVERFLOW_INT_EN
          int_req_db <= 1'b0;
`endif
        end
      end
      if (accept) begin
        db_wdata <= dev_wdata;
        to_cnt   <= '0;
      end
      if (fsm == REQ) to_cnt <= to_cnt + 1'b1;
      if (timeout_hit) db_timeout <= 1'b1;
      // Capture on the DB1 cycle itself so dev_rdata is already valid alongside dev_ack.
      if ((fsm == XFER0) && (state == DB1_STATE) && dir) dev_rdata <= mem_rdata;
      if (fsm == XFER1) begin
        ca <= ca + 12'd1;
        wc <= wc + 12'd1;
      end
      if ((fsm == DONE_CHK) && (wc == 12'd0)) begin
        done <= 1'b1;
        busy <= 1'b0;
`ifdef DB_OVERFLOW_INT_EN
        int_req_db <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_data_break_ctrl.sv
// Directed bench for data_break_ctrl: block transfers both directions, address wrap, timeout, async reset.
module tb_data_break_ctrl;
  localparam logic [4:0] DB0 = 5'd8;
  localparam logic [4:0] DB1 = 5'd9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  state = '0;
  logic        ld_ca = 1'b0, ld_wc = 1'b0, dir_to_disk = 1'b0, dev_req = 1'b0;
  logic [11:0] ld_data = '0, dev_wdata = '0, mem_rdata = '0;
  logic [2:0]  ld_field = '0;
  logic        data_break, to_disk, dev_ack, busy, done, db_timeout;
  logic [11:0] db_addr, db_wdata, dev_rdata;
  logic [2:0]  db_field;
`ifdef DB_OVERFLOW_INT_EN
  logic        int_req_db;
`endif

  int passed = 0;
  int total  = 0;

  data_break_ctrl #(.FIELD_W(3), .TIMEOUT(255), .DB0_STATE(DB0), .DB1_STATE(DB1)) dut (
    .clk(clk), .reset(reset), .state(state), .ld_ca(ld_ca), .ld_wc(ld_wc),
    .ld_data(ld_data), .ld_field(ld_field), .dir_to_disk(dir_to_disk),
    .dev_req(dev_req), .dev_wdata(dev_wdata), .mem_rdata(mem_rdata),
    .data_break(data_break), .to_disk(to_disk), .db_addr(db_addr),
    .db_field(db_field), .db_wdata(db_wdata), .dev_ack(dev_ack),
    .dev_rdata(dev_rdata), .busy(busy), .done(done),
`ifdef DB_OVERFLOW_INT_EN
    .int_req_db(int_req_db),
`endif
    .db_timeout(db_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
  endtask

  task automatic load(input logic [11:0] ca, input logic [2:0] fld,
                      input logic [11:0] wc, input logic dir);
    ld_ca = 1'b1; ld_data = ca; ld_field = fld;
    tick();
    ld_ca = 1'b0; ld_wc = 1'b1; ld_data = wc; dir_to_disk = dir;
    tick();
    ld_wc = 1'b0; ld_data = '0;
  endtask

  // DB0 is presented two clocks after data_break rises, DB1 on the following clock.
  task automatic do_word(input logic [11:0] w, input logic [11:0] ea, input logic [2:0] ef,
                         input logic ed, input logic [11:0] r);
    dev_req = 1'b1; dev_wdata = w;
    tick();
    dev_req = 1'b0; dev_wdata = 12'o7070;
    chk("req_break", data_break, 1);
    chk("req_addr", db_addr, ea);
    chk("req_field", db_field, ef);
    chk("req_wdata", db_wdata, w);
    chk("req_dir", to_disk, ed);
    tick();
    state = DB0;
    tick();
    state = DB1; mem_rdata = r;
    chk("x0_break", data_break, 1);
    chk("x0_dir", to_disk, ed);
    chk("x0_ack", dev_ack, 0);
    tick();
    state = '0; mem_rdata = '0;
    chk("x1_ack", dev_ack, 1);
    chk("x1_break", data_break, 0);
    chk("x1_addr", db_addr, ea);
    chk("x1_wdata", db_wdata, w);
    if (ed) chk("x1_rdata", dev_rdata, r);
    tick();
    chk("dc_ack", dev_ack, 0);
    tick();
  endtask

  initial begin
    logic ack_seen;
    tick();
    chk("rst_break", data_break, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", db_addr, 0);
    chk("rst_ack", dev_ack, 0);
    chk("rst_timeout", db_timeout, 0);
    reset = 1'b0;
    tick();

    // dev_req with WC=0 must be ignored
    dev_req = 1'b1; tick(); dev_req = 1'b0; tick();
    chk("idle_ignore", data_break, 0);

    // Block of three device-to-memory words
    load(12'o0200, 3'd2, 12'o7775, 1'b0);
    chk("t1_busy", busy, 1);
    do_word(12'o1111, 12'o0200, 3'd2, 1'b0, 12'o0);
    chk("t1_mid_done", done, 0);
    chk("t1_mid_busy", busy, 1);
    do_word(12'o2222, 12'o0201, 3'd2, 1'b0, 12'o0);
    do_word(12'o3333, 12'o0202, 3'd2, 1'b0, 12'o0);
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_ca", db_addr, 12'o0203);

    // Single memory-to-device word
    ld_wc = 1'b1; ld_data = 12'o7777; dir_to_disk = 1'b1;
    tick();
    ld_wc = 1'b0; dir_to_disk = 1'b0;
    chk("t2_done_clr", done, 0);
    do_word(12'o0, 12'o0203, 3'd2, 1'b1, 12'o4567);
    chk("t2_rdata_hold", dev_rdata, 12'o4567);
    chk("t2_done", done, 1);

    // Address wrap keeps the field
    load(12'o7777, 3'd5, 12'o7776, 1'b0);
    do_word(12'o0101, 12'o7777, 3'd5, 1'b0, 12'o0);
    do_word(12'o0202, 12'o0000, 3'd5, 1'b0, 12'o0);
    chk("t3_done", done, 1);
    chk("t3_field", db_field, 5);

    // Timeout: DB0 never arrives
    load(12'o0100, 3'd1, 12'o7777, 1'b0);
    dev_req = 1'b1; tick(); dev_req = 1'b0;
    chk("t4_break", data_break, 1);
    ack_seen = 1'b0;
    for (int i = 0; i < 254; i++) begin
      tick();
      ack_seen = ack_seen | dev_ack;
    end
    chk("t4_break_254", data_break, 1);
    chk("t4_to_early", db_timeout, 0);
    tick();
    ack_seen = ack_seen | dev_ack;
    chk("t4_timeout", db_timeout, 1);
    chk("t4_break_drop", data_break, 0);
    chk("t4_no_ack", ack_seen, 0);
    chk("t4_ca", db_addr, 12'o0100);
    chk("t4_busy", busy, 1);
    // WC untouched: one more word finishes the block
    do_word(12'o0707, 12'o0100, 3'd1, 1'b0, 12'o0);
    chk("t4_wc_done", done, 1);

    // Asynchronous reset in XFER0
    ld_wc = 1'b1; ld_data = 12'o7777; tick(); ld_wc = 1'b0;
    chk("t5_to_clr", db_timeout, 0);
    dev_req = 1'b1; dev_wdata = 12'o1234; tick(); dev_req = 1'b0;
    tick();
    state = DB0; tick();
    state = '0;
    chk("t5_in_x0", data_break, 1);
    #1 reset = 1'b1;
    #1;
    chk("t5_break", data_break, 0);
    chk("t5_ack", dev_ack, 0);
    chk("t5_busy", busy, 0);
    chk("t5_addr", db_addr, 0);
    tick();
    reset = 1'b0;
    tick();
    dev_req = 1'b1; tick(); dev_req = 1'b0; tick();
    chk("t5_idle", data_break, 0);

`ifdef DB_OVERFLOW_INT_EN
    chk("t6_rst", int_req_db, 0);
    load(12'o0400, 3'd0, 12'o7777, 1'b0);
    do_word(12'o0055, 12'o0400, 3'd0, 1'b0, 12'o0);
    chk("t6_int", int_req_db, 1);
    ld_wc = 1'b1; ld_data = 12'o7770; tick(); ld_wc = 1'b0;
    chk("t6_int_clr", int_req_db, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
